retire_trace_buf: RTL and testbench
===================================

Name: retire_trace_buf

Overview:
- Synthesizable flight recorder for retired uops; sits directly downstream of ROB retirement, consuming the same rb1 retire/nuke stream as the simulation core-debug tracker.
- Keeps the last DEPTH retire records in a ring, runs a no-retire hang watchdog, and freezes on hang, EBREAK or an explicit request.
- The frozen contents are drained over a valid/ready port, so a hang or EBREAK can be post-mortemed in silicon or FPGA builds where the simulation tracker does not exist.

Parameters:
- DEPTH, 16, ring entries; power of 2, minimum 2.
- PC_W, 32, PC width.
- DATA_W, 32, GPR result width.
- ROBID_W, 5, ROB id width.
- HANG_TIMEOUT, 40, consecutive RECORD cycles without a retire that declare a hang; minimum 1.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- ret_valid_rb1  in  1  one uop retires this cycle.
- ret_pc_rb1  in  PC_W  retiring PC.
- ret_robid_rb1  in  ROBID_W  retiring ROB id.
- ret_dst_vld_rb1  in  1  uop writes a GPR.
- ret_dst_reg_rb1  in  5  destination GPR index.
- ret_dst_data_rb1  in  DATA_W  value written.
- ret_nuke_rb1  in  1  retire caused a nuke.
- ret_ebreak_rb1  in  1  retiring uop is EBREAK.
- freeze_req  in  1  software/debugger freeze.
- drain_start  in  1  begin drain (honoured in FROZEN only).
- freeze_clr  in  1  flush and resume recording.
- tr_valid  out  1  drain record valid.
- tr_ready  in  1  drain consumer accepts.
- tr_pc, tr_robid, tr_dst_vld, tr_dst_reg, tr_dst_data, tr_nuke  out  widths as ret_*  oldest record.
- state  out  2  0=RECORD, 1=FROZEN, 2=DRAIN.
- hang  out  1  sticky, watchdog fired.
- ovf  out  1  sticky, an entry was overwritten.
- count  out  $clog2(DEPTH)+1  occupancy.
- retire_cnt  out  32  retires recorded since reset or clear; wraps at 2^32.

Behaviour:
- Reset (asynchronous, reset_n=0): state=RECORD, pointers=0, count=0, hang=0, ovf=0, retire_cnt=0, watchdog=0, tr_valid=0. Array contents are don't-care.
- RECORD, ret_valid_rb1=1:
  - The record is written at wptr on the next edge; wptr advances and retire_cnt increments.
  - If count<DEPTH, count increments.
  - If count==DEPTH, the oldest entry is overwritten: rptr advances too, count holds at DEPTH, ovf is set.
- Watchdog:
  - Counts only in RECORD. Cleared to 0 on any cycle with ret_valid_rb1, otherwise increments.
  - When the post-increment value equals HANG_TIMEOUT: hang=1, next state FROZEN. The counter saturates.
  - Retire in the same cycle the counter would hit the timeout: the retire wins, no hang.
- Transitions out of RECORD (the same-cycle retire is still recorded):
  - EBREAK retire -> FROZEN.
  - freeze_req -> FROZEN.
  - Several causes together -> FROZEN once; hang is set only by the watchdog.
- FROZEN:
  - Retires are ignored (not written, not counted); watchdog holds; tr_valid=0.
  - drain_start -> DRAIN.
- DRAIN:
  - tr_valid = (count!=0); tr_* combinationally show entry[rptr], oldest first.
  - tr_valid&tr_ready pops: rptr advances and count decrements next edge. tr_* are stable while tr_valid&!tr_ready.
  - When a pop leaves count==0 -> FROZEN. Entering DRAIN with count==0 -> FROZEN next cycle, with tr_valid never asserted.
- freeze_clr (any state, priority over every other event):
  - Next state RECORD; count, pointers, watchdog, hang, ovf and retire_cnt cleared. A same-cycle retire is dropped.
  - In RECORD with an empty buffer it only clears the counters.
- Pointers are $clog2(DEPTH) bits and wrap naturally; count distinguishes full from empty.
- ret_nuke_rb1 is recorded only; it does not affect buffer state.
- Reset mid-drain: everything returns to reset values immediately; a partially drained record is lost.

Test Plan:
- Reset, then 5 retires with PCs 0x100,0x104,…,0x110; freeze_req; drain_start; tr_ready=1 -> 5 records in PC order, count 5→0, state returns to FROZEN, retire_cnt=5, ovf=0.
- DEPTH=16, 20 retires with PC=0x1000+4n -> count=16, ovf=1; drain yields PCs 0x1010…0x104C.
- 3 retires, then 40 idle cycles -> hang=1 exactly on cycle 40 after the last retire, state=FROZEN; a retire on cycle 40 instead -> hang=0, watchdog restarts.
- Retire with ret_ebreak_rb1=1, dst x5=0x666 -> entry recorded, state=FROZEN next cycle; further retires leave count unchanged.
- Drain with tr_ready toggling 1,0,0,1 -> each record is held stable while tr_ready=0 and no record is duplicated or skipped; freeze_clr mid-drain -> state=RECORD, count=0, tr_valid=0 next cycle.
- Deassert reset_n asynchronously mid-DRAIN (between edges) -> all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/retire_trace_buf.sv
// Retire trace buffer: keeps the most recent DEPTH retire records in a ring.
// Recording stops on a no-retire hang, an EBREAK retire or a freeze request.
// The frozen contents then drain oldest-first over a valid/ready port.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RECORD   | capture every retire into the ring; the hang watchdog runs
// FROZEN   | ring contents held; retires ignored; waits for drain_start
// DRAIN    | present entry[rptr] on tr_*; pop on tr_valid & tr_ready
module retire_trace_buf #(
    parameter int DEPTH        = 16,
    parameter int PC_W         = 32,
    parameter int DATA_W       = 32,
    parameter int ROBID_W      = 5,
    parameter int HANG_TIMEOUT = 40
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       ret_valid_rb1,
    input  logic [PC_W-1:0]            ret_pc_rb1,
    input  logic [ROBID_W-1:0]         ret_robid_rb1,
    input  logic                       ret_dst_vld_rb1,
    input  logic [4:0]                 ret_dst_reg_rb1,
    input  logic [DATA_W-1:0]          ret_dst_data_rb1,
    input  logic                       ret_nuke_rb1,
    input  logic                       ret_ebreak_rb1,
    input  logic                       freeze_req,
    input  logic                       drain_start,
    input  logic                       freeze_clr,
    output logic                       tr_valid,
    input  logic                       tr_ready,
    output logic [PC_W-1:0]            tr_pc,
    output logic [ROBID_W-1:0]         tr_robid,
    output logic                       tr_dst_vld,
    output logic [4:0]                 tr_dst_reg,
    output logic [DATA_W-1:0]          tr_dst_data,
    output logic                       tr_nuke,
    output logic [1:0]                 state,
    output logic                       hang,
    output logic                       ovf,
    output logic [$clog2(DEPTH):0]     count,
    output logic [31:0]                retire_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(HANG_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [WD_W-1:0]  HANG_TC  = WD_W'(HANG_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RECORD = 2'd0,
        ST_FROZEN = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [WD_W-1:0]    wdog;
    logic [WD_W-1:0]    wdog_inc;
    logic               wdog_hit;
    logic               wr_en;
    logic               pop;

    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [ROBID_W-1:0] robid_mem [DEPTH];
    logic               dvld_mem  [DEPTH];
    logic [4:0]         dreg_mem  [DEPTH];
    logic [DATA_W-1:0]  data_mem  [DEPTH];
    logic               nuke_mem  [DEPTH];

    // Watchdog terminal count: an idle RECORD cycle that brings the counter to the timeout.
    // Once saturated the compare is masked so it cannot fire twice.
    always_comb begin
        wdog_inc = wdog + 1'b1;
        wdog_hit = !ret_valid_rb1 && (wdog != HANG_TC) && (wdog_inc == HANG_TC);
    end

    assign wr_en = (state_q == ST_RECORD) && ret_valid_rb1 && !freeze_clr;
    assign pop   = tr_valid && tr_ready;

    // Record storage; contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wptr]    <= ret_pc_rb1;
            robid_mem[wptr] <= ret_robid_rb1;
            dvld_mem[wptr]  <= ret_dst_vld_rb1;
            dreg_mem[wptr]  <= ret_dst_reg_rb1;
            data_mem[wptr]  <= ret_dst_data_rb1;
            nuke_mem[wptr]  <= ret_nuke_rb1;
        end
    end

    // Control FSM, ring pointers, watchdog and sticky status; freeze_clr overrides everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RECORD;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            wdog       <= '0;
            hang       <= 1'b0;
            ovf        <= 1'b0;
            retire_cnt <= '0;
        end else if (freeze_clr) begin
            state_q    <= ST_RECORD;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            wdog       <= '0;
            hang       <= 1'b0;
            ovf        <= 1'b0;
            retire_cnt <= '0;
        end else begin
            case (state_q)
                ST_RECORD: begin
                    if (ret_valid_rb1) begin
                        wptr       <= wptr + 1'b1;
                        retire_cnt <= retire_cnt + 32'd1;
                        wdog       <= '0;
                        if (count == FULL_CNT) begin
                            // Ring full: drop the oldest entry to make room.
                            rptr <= rptr + 1'b1;
                            ovf  <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end else if (wdog != HANG_TC) begin
                        wdog <= wdog_inc;
                    end
                    if (wdog_hit) begin
                        hang <= 1'b1;
                    end
                    if ((ret_valid_rb1 && ret_ebreak_rb1) || freeze_req || wdog_hit) begin
                        state_q <= ST_FROZEN;
                    end
                end
                ST_FROZEN: begin
                    if (drain_start) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (count == '0) begin
                        state_q <= ST_FROZEN;
                    end else if (pop) begin
                        rptr  <= rptr + 1'b1;
                        count <= count - 1'b1;
                        if (count == CNT_W'(1)) begin
                            state_q <= ST_FROZEN;
                        end
                    end
                end
                default: state_q <= ST_RECORD;
            endcase
        end
    end

    // Drain port shows the oldest entry combinationally so it is stable while stalled.
    always_comb begin
        tr_valid    = (state_q == ST_DRAIN) && (count != '0);
        tr_pc       = pc_mem[rptr];
        tr_robid    = robid_mem[rptr];
        tr_dst_vld  = dvld_mem[rptr];
        tr_dst_reg  = dreg_mem[rptr];
        tr_dst_data = data_mem[rptr];
        tr_nuke     = nuke_mem[rptr];
    end

    assign state = state_q;

endmodule

// File: tb/tb_retire_trace_buf.sv
// Testbench for retire_trace_buf: directed retire sequences with a drain scoreboard.
module tb_retire_trace_buf;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ret_valid_rb1 = 1'b0;
    logic [31:0] ret_pc_rb1 = '0;
    logic [4:0]  ret_robid_rb1 = '0;
    logic        ret_dst_vld_rb1 = 1'b0;
    logic [4:0]  ret_dst_reg_rb1 = '0;
    logic [31:0] ret_dst_data_rb1 = '0;
    logic        ret_nuke_rb1 = 1'b0;
    logic        ret_ebreak_rb1 = 1'b0;
    logic        freeze_req = 1'b0;
    logic        drain_start = 1'b0;
    logic        freeze_clr = 1'b0;
    logic        tr_valid;
    logic        tr_ready = 1'b0;
    logic [31:0] tr_pc;
    logic [4:0]  tr_robid;
    logic        tr_dst_vld;
    logic [4:0]  tr_dst_reg;
    logic [31:0] tr_dst_data;
    logic        tr_nuke;
    logic [1:0]  state;
    logic        hang;
    logic        ovf;
    logic [4:0]  count;
    logic [31:0] retire_cnt;

    retire_trace_buf #(
        .DEPTH(16), .PC_W(32), .DATA_W(32), .ROBID_W(5), .HANG_TIMEOUT(40)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .ret_valid_rb1(ret_valid_rb1), .ret_pc_rb1(ret_pc_rb1),
        .ret_robid_rb1(ret_robid_rb1), .ret_dst_vld_rb1(ret_dst_vld_rb1),
        .ret_dst_reg_rb1(ret_dst_reg_rb1), .ret_dst_data_rb1(ret_dst_data_rb1),
        .ret_nuke_rb1(ret_nuke_rb1), .ret_ebreak_rb1(ret_ebreak_rb1),
        .freeze_req(freeze_req), .drain_start(drain_start), .freeze_clr(freeze_clr),
        .tr_valid(tr_valid), .tr_ready(tr_ready),
        .tr_pc(tr_pc), .tr_robid(tr_robid), .tr_dst_vld(tr_dst_vld),
        .tr_dst_reg(tr_dst_reg), .tr_dst_data(tr_dst_data), .tr_nuke(tr_nuke),
        .state(state), .hang(hang), .ovf(ovf), .count(count), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  robid;
        logic        dv;
        logic [4:0]  rg;
        logic [31:0] data;
        logic        nuke;
    } rec_t;

    rec_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [4:0] rid, input logic dv,
                            input logic [4:0] rg, input logic [31:0] d, input logic nk);
        rec_t r;
        r.pc = pc; r.robid = rid; r.dv = dv; r.rg = rg; r.data = d; r.nuke = nk;
        exp_q.push_back(r);
    endtask

    // Monitor: pops expected records on each handshake and checks stall stability.
    logic        hold_pending = 1'b0;
    logic [31:0] held_pc;
    logic [31:0] held_data;
    always @(negedge clk) begin
        if (reset_n && tr_valid) begin
            if (hold_pending) begin
                chk("stall_pc_stable", tr_pc, held_pc);
                chk("stall_data_stable", tr_dst_data, held_data);
            end
            if (tr_ready) begin
                hold_pending = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_record_pc", tr_pc, 64'hDEAD_DEAD);
                end else begin
                    rec_t r;
                    r = exp_q.pop_front();
                    chk("drain_pc", tr_pc, r.pc);
                    chk("drain_data", tr_dst_data, r.data);
                    chk("drain_meta", {tr_robid, tr_dst_vld, tr_dst_reg, tr_nuke},
                        {r.robid, r.dv, r.rg, r.nuke});
                end
            end else begin
                hold_pending = 1'b1;
                held_pc      = tr_pc;
                held_data    = tr_dst_data;
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_retire(input logic [31:0] pc, input logic [4:0] rid, input logic dv,
                             input logic [4:0] rg, input logic [31:0] d, input logic nk,
                             input logic eb);
        ret_valid_rb1 = 1'b1; ret_pc_rb1 = pc; ret_robid_rb1 = rid;
        ret_dst_vld_rb1 = dv; ret_dst_reg_rb1 = rg; ret_dst_data_rb1 = d;
        ret_nuke_rb1 = nk; ret_ebreak_rb1 = eb;
        step();
        ret_valid_rb1 = 1'b0; ret_nuke_rb1 = 1'b0; ret_ebreak_rb1 = 1'b0;
    endtask

    task automatic pulse_freeze();
        freeze_req = 1'b1; step(); freeze_req = 1'b0;
    endtask

    task automatic pulse_clr();
        freeze_clr = 1'b1; step(); freeze_clr = 1'b0;
    endtask

    // Start a drain and run it to completion; toggle selects the 1,0,0,1 ready pattern.
    task automatic drain(input bit toggle, input string nm);
        int k;
        k = 0;
        drain_start = 1'b1; step(); drain_start = 1'b0;
        while (state != 2'd1 && k < 200) begin
            tr_ready = toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            step();
            k++;
        end
        tr_ready = 1'b0;
        chk({nm, "_end_state"}, state, 2'd1);
        chk({nm, "_end_count"}, count, 0);
        chk({nm, "_scoreboard_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        idle(2);
        chk("rst_state", state, 0);
        chk("rst_flags", {hang, ovf, tr_valid}, 0);
        chk("rst_count", count, 0);
        chk("rst_retire_cnt", retire_cnt, 0);
        reset_n = 1'b1;
        step();

        // Five retires, freeze, full-rate drain.
        for (int i = 0; i < 5; i++) begin
            do_retire(32'h100 + 32'(4 * i), 5'(i), 1'b1, 5'(i + 1), 32'hA0 + 32'(i), i == 2, 1'b0);
            push_exp(32'h100 + 32'(4 * i), 5'(i), 1'b1, 5'(i + 1), 32'hA0 + 32'(i), i == 2);
        end
        chk("t1_count", count, 5);
        pulse_freeze();
        chk("t1_frozen", state, 1);
        chk("t1_tr_valid_frozen", tr_valid, 0);
        drain(1'b0, "t1");
        chk("t1_retire_cnt", retire_cnt, 5);
        chk("t1_ovf", ovf, 0);

        // Twenty retires overflow a 16-entry ring; only the newest 16 remain.
        pulse_clr();
        chk("t2_clr_state", state, 0);
        chk("t2_clr_retire_cnt", retire_cnt, 0);
        for (int n = 0; n < 20; n++) begin
            do_retire(32'h1000 + 32'(4 * n), 5'(n), 1'b0, 5'd0, 32'(n), 1'b0, 1'b0);
        end
        for (int n = 4; n < 20; n++) push_exp(32'h1000 + 32'(4 * n), 5'(n), 1'b0, 5'd0, 32'(n), 1'b0);
        chk("t2_count_full", count, 16);
        chk("t2_ovf", ovf, 1);
        chk("t2_retire_cnt", retire_cnt, 20);
        pulse_freeze();
        drain(1'b0, "t2");

        // Watchdog fires exactly 40 idle cycles after the last retire.
        pulse_clr();
        for (int i = 0; i < 3; i++) do_retire(32'h300 + 32'(4 * i), 5'(i), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        idle(39);
        chk("t3_no_hang_39", hang, 0);
        chk("t3_record_39", state, 0);
        idle(1);
        chk("t3_hang_40", hang, 1);
        chk("t3_frozen_40", state, 1);

        // A retire on the 40th cycle wins; the watchdog restarts from zero.
        pulse_clr();
        chk("t3b_hang_cleared", hang, 0);
        for (int i = 0; i < 3; i++) do_retire(32'h400 + 32'(4 * i), 5'(i), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        idle(39);
        do_retire(32'h40C, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        chk("t3b_no_hang", hang, 0);
        chk("t3b_record", state, 0);
        chk("t3b_count", count, 4);
        idle(39);
        chk("t3b_no_hang_again", hang, 0);
        idle(1);
        chk("t3b_hang_restart", hang, 1);

        // EBREAK freezes after being recorded; later retires are ignored.
        pulse_clr();
        do_retire(32'h500, 5'd1, 1'b1, 5'd2, 32'h11, 1'b0, 1'b0);
        do_retire(32'h504, 5'd2, 1'b0, 5'd0, 32'h22, 1'b1, 1'b0);
        do_retire(32'h508, 5'd3, 1'b1, 5'd5, 32'h666, 1'b0, 1'b1);
        push_exp(32'h500, 5'd1, 1'b1, 5'd2, 32'h11, 1'b0);
        push_exp(32'h504, 5'd2, 1'b0, 5'd0, 32'h22, 1'b1);
        push_exp(32'h508, 5'd3, 1'b1, 5'd5, 32'h666, 1'b0);
        chk("t4_frozen", state, 1);
        chk("t4_count", count, 3);
        do_retire(32'h50C, 5'd4, 1'b1, 5'd6, 32'h77, 1'b0, 1'b0);
        do_retire(32'h510, 5'd5, 1'b1, 5'd7, 32'h88, 1'b0, 1'b0);
        chk("t4_count_held", count, 3);
        chk("t4_retire_cnt_held", retire_cnt, 3);
        drain(1'b1, "t4");

        // freeze_clr in the middle of a drain.
        pulse_clr();
        for (int i = 0; i < 4; i++) do_retire(32'h600 + 32'(4 * i), 5'(i), 1'b1, 5'(i), 32'h60 + 32'(i), 1'b0, 1'b0);
        push_exp(32'h600, 5'd0, 1'b1, 5'd0, 32'h60, 1'b0);
        pulse_freeze();
        drain_start = 1'b1; step(); drain_start = 1'b0;
        chk("t5_drain_state", state, 2);
        tr_ready = 1'b1; step(); tr_ready = 1'b0;
        chk("t5_count_after_pop", count, 3);
        freeze_clr = 1'b1; step(); freeze_clr = 1'b0;
        chk("t5_clr_state", state, 0);
        chk("t5_clr_count", count, 0);
        chk("t5_clr_tr_valid", tr_valid, 0);
        chk("t5_scoreboard_empty", exp_q.size(), 0);

        // Asynchronous reset between edges while draining.
        for (int i = 0; i < 3; i++) do_retire(32'h700 + 32'(4 * i), 5'(i), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        pulse_freeze();
        drain_start = 1'b1; step(); drain_start = 1'b0;
        idle(1);
        chk("t6_pre_valid", tr_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_state", state, 0);
        chk("t6_rst_tr_valid", tr_valid, 0);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_retire_cnt", retire_cnt, 0);
        chk("t6_rst_flags", {hang, ovf}, 0);
        step();
        reset_n = 1'b1;
        step();
        chk("final_scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
